// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and BCD constants for the stopwatch control slice
package stopwatch_pkg;

    localparam int BCD_W = 16;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - button synchronizer, optional debounce (STOPWATCH_DEBOUNCE_EN) and rising-edge pulse
module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk_10Hz,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [3:0] db_cnt;

    // Accepted level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk_10Hz or posedge rst_n) begin
        if (rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 4'd1;
        end
    end
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES != 0);
    assign level = sync2;
`endif

    always_ff @(posedge clk_10Hz or posedge rst_n) begin
        if (rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM, lap register and display mux; debounce via STOPWATCH_DEBOUNCE_EN
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter bit STOP_AT_MAX     = 1'b1,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic             clk_10Hz,
    input  logic             rst_n,
    input  logic             btn_start_stop,
    input  logic             btn_lap,
    input  logic             btn_clear,
    input  logic [BCD_W-1:0] bcd_in,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [BCD_W-1:0] disp_bcd,
    output logic [1:0]       state,
    output logic             ovf
);

    logic             ev_start_stop;
    logic             ev_lap;
    logic             ev_clear;
    logic             at_max;
    logic             counting;
    logic [BCD_W-1:0] lap_reg;

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
        .clk_10Hz (clk_10Hz),
        .rst_n    (rst_n),
        .btn      (btn_start_stop),
        .pulse    (ev_start_stop)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk_10Hz (clk_10Hz),
        .rst_n    (rst_n),
        .btn      (btn_lap),
        .pulse    (ev_lap)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk_10Hz (clk_10Hz),
        .rst_n    (rst_n),
        .btn      (btn_clear),
        .pulse    (ev_clear)
    );

    assign at_max   = STOP_AT_MAX && (bcd_in == BCD_MAX);
    assign counting = (state == S_RUN) || (state == S_LAP);

    // Clear beats the max-stop rule, which beats start_stop, which beats lap.
    always_ff @(posedge clk_10Hz or posedge rst_n) begin
        if (rst_n) begin
            state   <= S_IDLE;
            cnt_clr <= 1'b0;
            lap_reg <= '0;
            ovf     <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            if (ev_clear) begin
                state   <= S_IDLE;
                cnt_clr <= 1'b1;
                lap_reg <= '0;
                ovf     <= 1'b0;
            end else if (counting && at_max) begin
                state <= S_PAUSE;
                ovf   <= 1'b1;
            end else if (ev_start_stop) begin
                case (state)
                    S_IDLE:  state <= S_RUN;
                    S_RUN:   state <= S_PAUSE;
                    S_LAP:   state <= S_PAUSE;
                    default: state <= S_RUN;
                endcase
            end else if (ev_lap) begin
                if (state == S_RUN) begin
                    lap_reg <= bcd_in;
                    state   <= S_LAP;
                end else if (state == S_LAP) begin
                    state <= S_RUN;
                end
            end
        end
    end

    assign cnt_en   = counting && !at_max && !cnt_clr;
    assign disp_bcd = (state == S_LAP) ? lap_reg : bcd_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int LAT = 2 + 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk_10Hz;
    logic        rst_n;
    logic        btn_start_stop;
    logic        btn_lap;
    logic        btn_clear;
    logic [15:0] bcd_in;

    logic        a_cnt_en, a_cnt_clr, a_ovf;
    logic [15:0] a_disp;
    logic [1:0]  a_state;
    logic        b_cnt_en, b_cnt_clr, b_ovf;
    logic [15:0] b_disp;
    logic [1:0]  b_state;

    int n_assert = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(.STOP_AT_MAX(1'b1), .DEBOUNCE_CYCLES(3)) dut_a (
        .clk_10Hz       (clk_10Hz),
        .rst_n          (rst_n),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .bcd_in         (bcd_in),
        .cnt_en         (a_cnt_en),
        .cnt_clr        (a_cnt_clr),
        .disp_bcd       (a_disp),
        .state          (a_state),
        .ovf            (a_ovf)
    );

    stopwatch_ctrl #(.STOP_AT_MAX(1'b0), .DEBOUNCE_CYCLES(3)) dut_b (
        .clk_10Hz       (clk_10Hz),
        .rst_n          (rst_n),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .bcd_in         (bcd_in),
        .cnt_en         (b_cnt_en),
        .cnt_clr        (b_cnt_clr),
        .disp_bcd       (b_disp),
        .state          (b_state),
        .ovf            (b_ovf)
    );

    initial clk_10Hz = 1'b0;
    always #5 clk_10Hz = ~clk_10Hz;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_10Hz);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // m = {clear, lap, start_stop}; returns just after the edge that consumes the event.
    task automatic press(input logic [2:0] m);
        {btn_clear, btn_lap, btn_start_stop} = m;
        step(1 + LAT);
        {btn_clear, btn_lap, btn_start_stop} = 3'b000;
    endtask

    task automatic settle();
        step(LAT + 2);
    endtask

    initial begin
        rst_n          = 1'b1;
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        bcd_in         = 16'h1234;
        step(2);

        chk("rst_state",   16'(a_state),   16'h0);
        chk("rst_cnt_en",  16'(a_cnt_en),  16'h0);
        chk("rst_cnt_clr", 16'(a_cnt_clr), 16'h0);
        chk("rst_ovf",     16'(a_ovf),     16'h0);
        chk("rst_disp",    a_disp,         16'h1234);

        rst_n  = 1'b0;
        bcd_in = 16'h0000;
        step(2);

        // start latency and hold
        btn_start_stop = 1'b1;
        step(LAT);
        chk("start_early", 16'(a_state), 16'h0);
        step(1);
        chk("start_state",  16'(a_state),  16'h1);
        chk("start_cnt_en", 16'(a_cnt_en), 16'h1);
        step(20);
        chk("hold_state", 16'(a_state), 16'h1);
        btn_start_stop = 1'b0;
        settle();
        chk("release_state", 16'(a_state), 16'h1);

        // lap freeze
        bcd_in = 16'h0123;
        press(3'b010);
        chk("lap_state", 16'(a_state), 16'h3);
        chk("lap_disp",  a_disp,       16'h0123);
        bcd_in = 16'h0150;
        #1;
        chk("lap_frozen",  a_disp,         16'h0123);
        chk("lap_cnt_en",  16'(a_cnt_en),  16'h1);
        settle();
        press(3'b010);
        chk("unlap_state", 16'(a_state), 16'h1);
        chk("unlap_disp",  a_disp,       16'h0150);
        settle();

        // clear and start_stop together from RUN
        press(3'b101);
        chk("sim_state",   16'(a_state),   16'h0);
        chk("sim_cnt_clr", 16'(a_cnt_clr), 16'h1);
        chk("sim_cnt_en",  16'(a_cnt_en),  16'h0);
        step(1);
        chk("sim_clr_once", 16'(a_cnt_clr), 16'h0);
        chk("sim_state2",   16'(a_state),   16'h0);
        settle();

        // reset mid-operation from LAP
        press(3'b001);
        settle();
        bcd_in = 16'h0200;
        press(3'b010);
        chk("lap2_disp", a_disp, 16'h0200);
        bcd_in = 16'h0210;
        rst_n  = 1'b1;
        #1;
        chk("midrst_state",  16'(a_state),  16'h0);
        chk("midrst_cnt_en", 16'(a_cnt_en), 16'h0);
        chk("midrst_disp",   a_disp,        16'h0210);
        step(1);
        rst_n = 1'b0;
        step(1);
        chk("midrst_ovf", 16'(a_ovf), 16'h0);

        // max handling
        press(3'b001);
        settle();
        bcd_in = 16'h9999;
        #1;
        chk("max_cnt_en_a", 16'(a_cnt_en), 16'h0);
        chk("max_cnt_en_b", 16'(b_cnt_en), 16'h1);
        step(1);
        chk("max_state_a", 16'(a_state), 16'h2);
        chk("max_ovf_a",   16'(a_ovf),   16'h1);
        chk("max_state_b", 16'(b_state), 16'h1);
        chk("max_ovf_b",   16'(b_ovf),   16'h0);
        press(3'b001);
        chk("max_rerun",     16'(a_state),  16'h1);
        chk("max_rerun_en",  16'(a_cnt_en), 16'h0);
        chk("max_rerun_ovf", 16'(a_ovf),    16'h1);
        step(1);
        chk("max_repause", 16'(a_state), 16'h2);
        bcd_in = 16'h0000;
        settle();
        press(3'b100);
        chk("clr_state", 16'(a_state),   16'h0);
        chk("clr_ovf",   16'(a_ovf),     16'h0);
        chk("clr_pulse", 16'(a_cnt_clr), 16'h1);
        settle();

`ifdef STOPWATCH_DEBOUNCE_EN
        btn_start_stop = 1'b1;
        step(2);
        btn_start_stop = 1'b0;
        step(10);
        chk("glitch_state", 16'(a_state), 16'h0);
        btn_start_stop = 1'b1;
        step(4);
        btn_start_stop = 1'b0;
        step(LAT - 4);
        chk("db_early", 16'(a_state), 16'h0);
        step(1);
        chk("db_press", 16'(a_state), 16'h1);
        settle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the 4-digit BCD stopwatch counter running on the 10 Hz tick clock.
- Turns three push-button inputs into enable and clear strobes for the counter datapath.
- Captures and freezes a lap value.
- Selects the live count or the lap value for the display path.
- Optionally stops the counter at 9999 and flags the overflow.

Parameters:
- STOP_AT_MAX, 1: 1 = hold the count at 9999 and set ovf; 0 = let the counter wrap 9999->0000 freely.
- DEBOUNCE_CYCLES, 3: number of consecutive equal samples needed to accept a button level. Used only when debounce is compiled in; range 1..15.

Ports:
- clk_10Hz  in  1  tick clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-high despite the name.
- btn_start_stop  in  1  raw button, asynchronous level.
- btn_lap  in  1  raw button, asynchronous level.
- btn_clear  in  1  raw button, asynchronous level.
- bcd_in  in  16  live count {thousands,tens... i.e. thousands[15:12], hundreds[11:8], tens[7:4], ones[3:0]}.
- cnt_en  out  1  counter increment enable.
- cnt_clr  out  1  synchronous counter clear, one-cycle pulse.
- disp_bcd  out  16  value to display.
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.
- ovf  out  1  sticky overflow flag (count reached 9999 with STOP_AT_MAX=1).

Behaviour:
- Reset (rst_n=1, async): state=IDLE, cnt_clr=0, lap_reg=0000, ovf=0, synchronizer flops=0. While held, cnt_en=0 and disp_bcd=bcd_in.
- Button conditioning, per button:
  - 2-FF synchronizer, then a third flop for rising-edge detect.
  - A press that is high before edge k gives a one-cycle event used at edge k+2. State is visible after edge k+2.
  - Holding a button produces exactly one event. Releasing it produces none.
- Event priority when several occur in one cycle: clear > start_stop > lap. Lower-priority events in that cycle are discarded.
- Transitions:
  - clear: any state -> IDLE. cnt_clr=1 for exactly one cycle (registered, same edge). lap_reg=0000, ovf=0.
  - start_stop: IDLE->RUN, RUN->PAUSE, LAP->PAUSE, PAUSE->RUN.
  - lap in RUN: lap_reg<=bcd_in at that edge, go to LAP.
  - lap in LAP: go to RUN; lap_reg keeps its value.
  - lap in IDLE or PAUSE: ignored.
- Max handling (STOP_AT_MAX=1):
  - In RUN or LAP with bcd_in==16'h9999, transition to PAUSE at the next edge and set ovf=1.
  - A start_stop event in that same cycle loses to this rule.
  - PAUSE->RUN while bcd_in==9999 returns to PAUSE on the next edge; ovf stays 1.
  - With STOP_AT_MAX=0, ovf is held at 0.
- cnt_en (combinational): (state==RUN or state==LAP) AND NOT (STOP_AT_MAX and bcd_in==16'h9999) AND NOT cnt_clr. The counter therefore never wraps when STOP_AT_MAX=1.
- disp_bcd (combinational): lap_reg when state==LAP, else bcd_in.
- bcd_in is trusted to be valid BCD; there is no range check.
- Reset asserted mid-operation aborts everything immediately. Pending edge events are lost.

Optional Feature:
- Macro STOPWATCH_DEBOUNCE_EN.
- Defined: a per-button 4-bit stability counter sits after the synchronizer. The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples, so press latency becomes k+2+DEBOUNCE_CYCLES. Glitches shorter than that produce no event.
- Undefined: no debounce logic, latency k+2 as above.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding localparams S_IDLE=2'b00, S_RUN=2'b01, S_PAUSE=2'b10, S_LAP=2'b11;
  - BCD_MAX=16'h9999;
  - BCD_W=16.
- Sub-module btn_cond: synchronizer, optional debounce and rising-edge pulse, with DEBOUNCE_CYCLES passed through. Instantiated three times.
- The FSM, lap register and output muxing stay in the top.

Test Plan:
- Reset mid-RUN: assert rst_n for 1 cycle -> state=00, cnt_en=0, ovf=0, lap_reg cleared (confirm via a later lap).
- Start latency: btn_start_stop high before edge 5 -> state=01 and cnt_en=1 after edge 7. Held high for 20 cycles -> no second transition.
- Lap freeze: in RUN at bcd_in=0123, pulse lap -> state=11, disp_bcd=0123 while bcd_in advances to 0150, cnt_en still 1. Lap again -> state=01, disp_bcd=bcd_in.
- Simultaneous events: clear and start_stop events in the same cycle from RUN -> state=00, cnt_clr high exactly 1 cycle, no RUN/PAUSE change.
- Max stop: STOP_AT_MAX=1, RUN with bcd_in=9999 -> cnt_en=0 in that cycle, state=10 and ovf=1 next edge. start_stop -> RUN for one cycle, back to PAUSE.
- STOP_AT_MAX=0 with bcd_in=9999 in RUN -> cnt_en=1, state stays 01, ovf=0. With STOPWATCH_DEBOUNCE_EN and DEBOUNCE_CYCLES=3, a 2-cycle button glitch -> no event; a 4-cycle press -> one event at k+5.
